ram_sp_req_ctrl: RTL and testbench

Initiator-side controller for the single-port write-first block RAM. It accepts read/write requests on a valid/ready channel and drives the RAM port (en, we, addr, di). It captures the RAM's one-cycle-latency dout and returns exactly one response per request, in order, through a buffered valid/ready response channel. It sits between any client (core, DMA, test engine) and a write-first RAM instance, so clients never track RAM latency or stall the RAM on backpressure.

---
 rtl/ram_sp_req_ctrl.sv | 88 ++++++++
 tb/tb_ram_sp_req_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_req_ctrl.sv
// Request-side controller for a single-port write-first RAM: drives the RAM
// on accept, captures the 1-cycle-latency dout and returns in-order responses.
module ram_sp_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  rsp_t          mem [RSP_DEPTH];
  rsp_t          head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          inflight, inflight_we;
  logic          accept, push, pop;

  // Credit counts the inflight slot too, so a capture always has room and
  // req_ready never depends on rsp_ready.
  assign used      = {1'b0, count} + (CW+1)'(inflight);
  assign req_ready = rst_n & (used < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;

  assign ram_en   = accept;
  assign ram_we   = accept & req_we;
  assign ram_addr = req_addr;
  assign ram_di   = req_wdata;

  assign push = inflight;
  assign pop  = rsp_valid & rsp_ready;

  assign head      = mem[rd_ptr];
  assign rsp_valid = (count != '0);
  assign rsp_we    = rsp_valid & head.we;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign busy      = inflight | rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= accept;
      if (accept) inflight_we <= req_we;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only; the pointers and count carry all the reset state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{we: inflight_we, data: ram_dout};
  end

endmodule

// File: tb/tb_ram_sp_req_ctrl.sv
// Scoreboard bench for ram_sp_req_ctrl with behavioural write-first RAMs,
// one instance at RSP_DEPTH=4 and one at RSP_DEPTH=2.
module tb_ram_sp_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // depth-4 instance
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_we, busy, ram_en, ram_we;
  logic [7:0] rsp_data, ram_addr, ram_di, ram_dout;

  // depth-2 instance
  logic       v2 = 1'b0, rr2 = 1'b1;
  logic [7:0] a2 = '0;
  logic       rdy2, rv2, rwe2, busy2, en2, we2;
  logic [7:0] rd2, ra2, rdi2, rdo2;

  ram_sp_req_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  ram_sp_req_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v2), .req_ready(rdy2), .req_we(1'b0),
    .req_addr(a2), .req_wdata(8'h00),
    .rsp_valid(rv2), .rsp_ready(rr2), .rsp_we(rwe2), .rsp_data(rd2),
    .busy(busy2), .ram_en(en2), .ram_we(we2), .ram_addr(ra2),
    .ram_di(rdi2), .ram_dout(rdo2)
  );

  // write-first RAM models
  logic [7:0] mem [256];
  logic [7:0] mem2 [256];
  initial for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mem2[i] = 8'(i) ^ 8'h5A; end

  always @(posedge clk) if (ram_en) begin
    if (ram_we) begin mem[ram_addr] <= ram_di; ram_dout <= ram_di; end
    else ram_dout <= mem[ram_addr];
  end
  always @(posedge clk) if (en2) begin
    if (we2) begin mem2[ra2] <= rdi2; rdo2 <= rdi2; end
    else rdo2 <= mem2[ra2];
  end

  int errors = 0, checks = 0, stalls = 0, accepted = 0;
  logic [8:0] q[$];
  logic [8:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // response monitors: pop expected entry whenever a response is consumed
  always @(negedge clk) if (rst_n && rsp_valid && rsp_ready) begin
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rsp_extra: got %h expected none", {rsp_we, rsp_data});
    end else chk("rsp", 32'({rsp_we, rsp_data}), 32'(q.pop_front()));
  end
  always @(negedge clk) if (rst_n && rv2 && rr2) begin
    if (q2.size() == 0) begin
      checks++; errors++;
      $display("FAIL rsp2_extra: got %h expected none", {rwe2, rd2});
    end else chk("rsp2", 32'({rwe2, rd2}), 32'(q2.pop_front()));
  end

  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic [8:0] exp);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        q.push_back(exp); accepted++;
        @(posedge clk); #1;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got no accept expected accept addr %h", a);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("drain", 32'(q.size() + q2.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] pat;
    int k;
    // reset with a pending request
    req_valid = 1'b1; req_addr = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", 32'({req_ready, ram_en, ram_we, rsp_valid, busy, rsp_we}), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // write then read, latency 2
    send(1'b1, 8'h10, 8'hA5, 9'h1A5);
    send(1'b0, 8'h10, 8'h00, 9'h0A5);
    req_valid = 1'b0;
    @(negedge clk); chk("lat_wr", 32'({rsp_valid, rsp_we, rsp_data}), 32'h3A5);
    @(negedge clk); chk("lat_rd", 32'({rsp_valid, rsp_we, rsp_data}), 32'h2A5);
    drain();

    // streaming 16 writes + 16 reads
    stalls = 0;
    for (int i = 0; i < 16; i++) send(1'b1, 8'(i), 8'(i) ^ 8'h3C, {1'b1, 8'(i) ^ 8'h3C});
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i), 8'h00, {1'b0, 8'(i) ^ 8'h3C});
    req_valid = 1'b0;
    chk("stream_stalls", 32'(stalls), 32'd0);
    drain();

    // backpressure: only 4 of 6 reads accepted until responses drain
    rsp_ready = 1'b0; accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 8'h00, {1'b0, 8'(i) ^ 8'h3C});
        req_valid = 1'b0;
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 32'(accepted), 32'd4);
        chk("bp_ctl", 32'({req_ready, rsp_valid, busy}), 32'b011);
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    chk("bp_total", 32'(accepted), 32'd6);
    drain();

    // reset with 3 buffered + 1 inflight (a write)
    rsp_ready = 1'b0;
    send(1'b0, 8'h01, 8'h00, {1'b0, 8'h3D});
    send(1'b0, 8'h02, 8'h00, {1'b0, 8'h3E});
    send(1'b0, 8'h03, 8'h00, {1'b0, 8'h3F});
    send(1'b1, 8'h20, 8'h5A, 9'h15A);
    req_valid = 1'b0;
    chk("pre_rst", 32'({req_ready, rsp_valid, busy}), 32'b011);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'hFF;
    rst_n = 1'b0; q.delete();
    #1 chk("rst_mid", 32'({rsp_valid, busy, req_ready, ram_en, ram_we}), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_en", 32'({ram_en, rsp_valid}), 32'd0);
    req_valid = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1;
    send(1'b0, 8'h20, 8'h00, 9'h05A);
    req_valid = 1'b0;
    drain();

    // depth 2: continuous requests give accept pattern 1,1,0
    k = 0; a2 = 8'h00; v2 = 1'b1; pat = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pat[8-c] = rdy2;
      if (rdy2) q2.push_back({1'b0, 8'(k) ^ 8'h5A});
      @(posedge clk); #1;
      if (pat[8-c]) begin k++; a2 = 8'(k); end
    end
    v2 = 1'b0;
    chk("d2_pattern", 32'(pat), 32'b110110110);
    drain();
    repeat (3) @(negedge clk);
    chk("idle_end", 32'({busy, busy2, rsp_valid, rv2}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
